booth_seq_ctrl: RTL and testbench

Clocked sequencer and two-port arbiter for the 8-bit Booth multiplier datapath. It accepts signed 8x8 multiply requests from two requesters over valid/ready handshakes. It drives the datapath's 3-bit `enable` command code and 8-bit `inbus` through INITIALIZE, LOAD_Q, LOAD_M, RUN, STORE_A and STORE_Q. It collects the two halves of the product from `outbus` and returns one tagged 16-bit product per request.

---
 rtl/booth_seq_ctrl.sv | 175 +++++++++++++++++
 tb/tb_booth_seq_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_seq_ctrl.sv
// Sequencer and two-port round-robin arbiter for the 8-bit Booth multiplier
// datapath. It accepts signed 8x8 requests, steps the datapath through
// INITIALIZE / LOAD_Q / LOAD_M / RUN / STORE_A / STORE_Q, and returns a tagged
// 16-bit {A,Q} product per request.
module booth_seq_ctrl #(
    parameter int RUN_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [7:0]  req0_q,
    input  logic [7:0]  req0_m,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [7:0]  req1_q,
    input  logic [7:0]  req1_m,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_product,
    output logic [2:0]  dp_enable,
    output logic [7:0]  dp_inbus,
    input  logic [7:0]  dp_outbus,
    output logic        busy
);

    localparam int CW = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
    localparam logic [CW-1:0] RUN_LAST = CW'(RUN_CYCLES - 1);

    // Datapath command codes
    localparam logic [2:0] EN_NOP  = 3'b000;
    localparam logic [2:0] EN_INIT = 3'b001;
    localparam logic [2:0] EN_LDQ  = 3'b010;
    localparam logic [2:0] EN_LDM  = 3'b011;
    localparam logic [2:0] EN_RUN  = 3'b100;
    localparam logic [2:0] EN_STA  = 3'b101;
    localparam logic [2:0] EN_STQ  = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_LDQ,
        ST_LDM,
        ST_RUN,
        ST_STA,
        ST_STQ,
        ST_RESP
    } state_t;

    state_t          state_reg;
    logic            last_grant_reg;
    logic            id_reg;
    logic [7:0]      q_reg;
    logic [7:0]      m_reg;
    logic [15:0]     product_reg;
    logic [CW-1:0]   run_cnt_reg;

    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [7:0]      req_q [2];
    logic [7:0]      req_m [2];
    logic            grant_any;
    logic            grant_id;
    logic            accept;

    assign req_valid = {req1_valid, req0_valid};
    assign req_q[0]  = req0_q;
    assign req_q[1]  = req1_q;
    assign req_m[0]  = req0_m;
    assign req_m[1]  = req1_m;

    // Round-robin pick: a lone requester wins; on a tie the one not granted last wins
    always_comb begin
        grant_any = req0_valid | req1_valid;
        grant_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant_reg;
        end else begin
            grant_id = req1_valid;
        end
    end

    // Ready only in IDLE, out of reset, and only for the selected requester
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = (state_reg == ST_IDLE) && !rst && grant_any &&
                                   req_valid[gi] && (grant_id == 1'(gi));
        end
    endgenerate

    assign req0_ready = req_ready[0];
    assign req1_ready = req_ready[1];
    assign accept     = |req_ready;

    // Sequencer: operand latch, run counter, product capture and response hold
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= 1'b1;
            id_reg         <= 1'b0;
            q_reg          <= 8'h00;
            m_reg          <= 8'h00;
            product_reg    <= 16'h0000;
            run_cnt_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        q_reg          <= req_q[grant_id];
                        m_reg          <= req_m[grant_id];
                        id_reg         <= grant_id;
                        last_grant_reg <= grant_id;
                        state_reg      <= ST_INIT;
                    end
                end
                ST_INIT: state_reg <= ST_LDQ;
                ST_LDQ:  state_reg <= ST_LDM;
                ST_LDM: begin
                    run_cnt_reg <= '0;
                    state_reg   <= ST_RUN;
                end
                ST_RUN: begin
                    if (run_cnt_reg == RUN_LAST) begin
                        state_reg <= ST_STA;
                    end else begin
                        run_cnt_reg <= run_cnt_reg + 1'b1;
                    end
                end
                ST_STA: begin
                    product_reg[15:8] <= dp_outbus;
                    state_reg         <= ST_STQ;
                end
                ST_STQ: begin
                    product_reg[7:0] <= dp_outbus;
                    state_reg        <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Datapath command and operand bus, decoded from the state register only
    always_comb begin
        dp_enable = EN_NOP;
        dp_inbus  = 8'h00;
        case (state_reg)
            ST_INIT: dp_enable = EN_INIT;
            ST_LDQ: begin
                dp_enable = EN_LDQ;
                dp_inbus  = q_reg;
            end
            ST_LDM: begin
                dp_enable = EN_LDM;
                dp_inbus  = m_reg;
            end
            ST_RUN:  dp_enable = EN_RUN;
            ST_STA:  dp_enable = EN_STA;
            ST_STQ:  dp_enable = EN_STQ;
            default: dp_enable = EN_NOP;
        endcase
    end

    assign rsp_valid   = (state_reg == ST_RESP);
    assign rsp_id      = id_reg;
    assign rsp_product = product_reg;
    assign busy        = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Directed bench for booth_seq_ctrl with a behavioural Booth datapath model
// answering on dp_outbus. Expected products are hand-computed constants.
module tb_booth_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0]  req0_q, req0_m, req1_q, req1_m;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [15:0] rsp_product;
    logic [2:0]  dp_enable;
    logic [7:0]  dp_inbus, dp_outbus;
    logic        busy;

    // second instance with RUN_CYCLES = 10
    logic        b_req0_valid, b_req0_ready, b_req1_ready;
    logic [7:0]  b_req0_q, b_req0_m;
    logic        b_rsp_valid, b_rsp_id;
    logic [15:0] b_rsp_product;
    logic [2:0]  b_dp_enable;
    logic [7:0]  b_dp_inbus, b_dp_outbus;
    logic        b_busy;

    booth_seq_ctrl u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_q(req0_q), .req0_m(req0_m),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_q(req1_q), .req1_m(req1_m),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_product(rsp_product),
        .dp_enable(dp_enable), .dp_inbus(dp_inbus), .dp_outbus(dp_outbus), .busy(busy)
    );

    booth_seq_ctrl #(.RUN_CYCLES(10)) u_dut10 (
        .clk(clk), .rst(rst),
        .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_q(b_req0_q), .req0_m(b_req0_m),
        .req1_valid(1'b0), .req1_ready(b_req1_ready), .req1_q(8'h00), .req1_m(8'h00),
        .rsp_valid(b_rsp_valid), .rsp_ready(1'b1), .rsp_id(b_rsp_id), .rsp_product(b_rsp_product),
        .dp_enable(b_dp_enable), .dp_inbus(b_dp_inbus), .dp_outbus(b_dp_outbus), .busy(b_busy)
    );

    // ---------------- behavioural radix-2 Booth datapath ----------------
    typedef struct packed {
        logic [7:0] a;
        logic [7:0] q;
        logic [7:0] m;
        logic       q1;
        logic [3:0] cnt;
    } dp_t;

    function automatic dp_t dp_next(dp_t s, logic [2:0] en, logic [7:0] inb);
        dp_t n;
        logic [7:0] t;
        n = s;
        t = s.a;
        case (en)
            3'b001: begin n.a = 8'h00; n.q1 = 1'b0; n.cnt = 4'd0; end
            3'b010: n.q = inb;
            3'b011: n.m = inb;
            3'b100: begin
                if (s.cnt < 4'd8) begin
                    if ({s.q[0], s.q1} == 2'b01) t = s.a + s.m;
                    else if ({s.q[0], s.q1} == 2'b10) t = s.a - s.m;
                    n.q1  = s.q[0];
                    n.q   = {t[0], s.q[7:1]};
                    n.a   = {t[7], t[7:1]};
                    n.cnt = s.cnt + 4'd1;
                end
            end
            default: ;
        endcase
        return n;
    endfunction

    function automatic logic [7:0] dp_out(dp_t s, logic [2:0] en);
        if (en == 3'b101) return s.a;
        if (en == 3'b110) return s.q;
        return 8'h00;
    endfunction

    dp_t dp_a = '0;
    dp_t dp_b = '0;
    always @(posedge clk) dp_a <= dp_next(dp_a, dp_enable, dp_inbus);
    always @(posedge clk) dp_b <= dp_next(dp_b, b_dp_enable, b_dp_inbus);
    assign dp_outbus   = dp_out(dp_a, dp_enable);
    assign b_dp_outbus = dp_out(dp_b, b_dp_enable);

    // ---------------- cycle counter and monitor ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0]  en_hist  [0:1023];
    logic [7:0]  inb_hist [0:1023];
    int          acc_cyc_q[$];
    bit          acc_id_q[$];
    bit          rsp_id_q[$];
    logic [15:0] rsp_prod_q[$];

    always @(negedge clk) begin
        en_hist[cyc % 1024]  = dp_enable;
        inb_hist[cyc % 1024] = dp_inbus;
        if (req0_valid && req0_ready) begin acc_cyc_q.push_back(cyc); acc_id_q.push_back(1'b0); end
        if (req1_valid && req1_ready) begin acc_cyc_q.push_back(cyc); acc_id_q.push_back(1'b1); end
        if (rsp_valid && rsp_ready) begin rsp_id_q.push_back(rsp_id); rsp_prod_q.push_back(rsp_product); end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        acc_cyc_q.delete();
        acc_id_q.delete();
        rsp_id_q.delete();
        rsp_prod_q.delete();
    endtask

    // Present a request and hold it until accepted; operands are scrambled afterwards
    task automatic do_req(input bit id, input logic [7:0] q, input logic [7:0] m, output int acc);
        acc = -1;
        if (id) begin req1_valid = 1'b1; req1_q = q; req1_m = m; end
        else    begin req0_valid = 1'b1; req0_q = q; req0_m = m; end
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((id ? req1_ready : req0_ready) === 1'b1) begin acc = cyc; break; end
        end
        @(posedge clk); #1;
        if (id) begin req1_valid = 1'b0; req1_q = 8'hAA; req1_m = 8'h55; end
        else    begin req0_valid = 1'b0; req0_q = 8'hAA; req0_m = 8'h55; end
        if (acc < 0) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_rsp(output int rc);
        rc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin rc = cyc; break; end
        end
        if (rc < 0) check("rsp_timeout", 32'd0, 32'd1);
    endtask

    // Full operation with rsp_ready high: latency, id and product checks
    task automatic run_op(input string tag, input bit id, input logic [7:0] q, input logic [7:0] m,
                          input logic [15:0] exp_p, output int acc);
        int rc;
        do_req(id, q, m, acc);
        wait_rsp(rc);
        check({tag, "_latency"}, 32'(rc - acc), 32'd14);
        check({tag, "_id"}, 32'(rsp_id), 32'(id));
        check({tag, "_product"}, 32'(rsp_product), 32'(exp_p));
        $display("txn %s: id=%0d q=0x%02h m=0x%02h product=0x%04h", tag, id, q, m, rsp_product);
        @(posedge clk); #1;
    endtask

    int acc, rc;
    logic [2:0] exp_en;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req0_valid = 1'b1; req0_q = 8'h00; req0_m = 8'h00;
        req1_valid = 1'b1; req1_q = 8'h00; req1_m = 8'h00;
        rsp_ready = 1'b1;
        b_req0_valid = 1'b0; b_req0_q = 8'h00; b_req0_m = 8'h00;

        // ---- reset state (requests valid while in reset) ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_enable", 32'(dp_enable), 32'd0);
        check("rst_inbus", 32'(dp_inbus), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_product", 32'(rsp_product), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req0_ready", 32'(req0_ready), 32'd0);
        check("rst_req1_ready", 32'(req1_ready), 32'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0; rst = 1'b0;
        @(posedge clk); #1;

        // ---- basic multiply with command sequence ----
        run_op("basic", 1'b0, 8'h03, 8'h05, 16'h000F, acc);
        for (int k = 1; k <= 14; k++) begin
            if (k <= 3)       exp_en = 3'(k);
            else if (k <= 11) exp_en = 3'd4;
            else if (k == 12) exp_en = 3'd5;
            else if (k == 13) exp_en = 3'd6;
            else              exp_en = 3'd0;
            check($sformatf("basic_enable_T+%0d", k), 32'(en_hist[(acc + k) % 1024]), 32'(exp_en));
        end
        check("basic_inbus_init", 32'(inb_hist[(acc + 1) % 1024]), 32'h00);
        check("basic_inbus_ldq", 32'(inb_hist[(acc + 2) % 1024]), 32'h03);
        check("basic_inbus_ldm", 32'(inb_hist[(acc + 3) % 1024]), 32'h05);

        // ---- signed operands ----
        run_op("signed_fd_05", 1'b1, 8'hFD, 8'h05, 16'hFFF1, acc);
        run_op("signed_80_7f", 1'b0, 8'h80, 8'h7F, 16'hC080, acc);
        run_op("signed_ff_ff", 1'b1, 8'hFF, 8'hFF, 16'h0001, acc);

        // ---- arbitration: both held valid from reset ----
        rst = 1'b1;
        @(posedge clk); #1;
        clear_mon();
        req0_valid = 1'b1; req0_q = 8'h02; req0_m = 8'h03;
        req1_valid = 1'b1; req1_q = 8'h04; req1_m = 8'h05;
        rst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rsp_id_q.size() >= 4) break;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        if (acc_id_q.size() >= 4 && rsp_id_q.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("arb_grant%0d", i), 32'(acc_id_q[i]), 32'(i % 2));
                check($sformatf("arb_rsp_id%0d", i), 32'(rsp_id_q[i]), 32'(i % 2));
                check($sformatf("arb_product%0d", i), 32'(rsp_prod_q[i]),
                      (i % 2) ? 32'h0014 : 32'h0006);
                if (i > 0)
                    check($sformatf("arb_spacing%0d", i), 32'(acc_cyc_q[i] - acc_cyc_q[i-1]), 32'd15);
                $display("txn arb%0d: id=%0d product=0x%04h", i, rsp_id_q[i], rsp_prod_q[i]);
            end
        end else begin
            check("arb_count", 32'(rsp_id_q.size()), 32'd4);
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // ---- response back-pressure ----
        rsp_ready = 1'b0;
        do_req(1'b0, 8'h09, 8'hFE, acc);
        wait_rsp(rc);
        check("bp_latency", 32'(rc - acc), 32'd14);
        @(posedge clk); #1;
        req1_valid = 1'b1; req1_q = 8'h33; req1_m = 8'h02;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_id", 32'(rsp_id), 32'd0);
            check("bp_rsp_product", 32'(rsp_product), 32'hFFEE);
            check("bp_req0_ready", 32'(req0_ready), 32'd0);
            check("bp_req1_ready", 32'(req1_ready), 32'd0);
            check("bp_busy", 32'(busy), 32'd1);
        end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 32'(rsp_valid), 32'd1);
        $display("txn bp: id=%0d product=0x%04h", rsp_id, rsp_product);
        @(negedge clk);
        check("bp_idle_busy", 32'(busy), 32'd0);
        check("bp_idle_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;

        // ---- reset mid-RUN ----
        do_req(1'b0, 8'h11, 8'h03, acc);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_was_run", 32'(en_hist[(acc + 6) % 1024]), 32'd4);
        check("midrst_enable", 32'(dp_enable), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        clear_mon();
        // tie after reset: req0 must win again since last_grant was reset
        req0_valid = 1'b1; req0_q = 8'h07; req0_m = 8'h06;
        req1_valid = 1'b1; req1_q = 8'h01; req1_m = 8'h01;
        acc = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req0_ready === 1'b1 || req1_ready === 1'b1) begin acc = cyc; break; end
        end
        check("midrst_tie_req0_ready", 32'(req0_ready), 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp(rc);
        check("midrst_latency", 32'(rc - acc), 32'd14);
        check("midrst_id", 32'(rsp_id), 32'd0);
        check("midrst_product", 32'(rsp_product), 32'h002A);
        $display("txn midrst: id=%0d product=0x%04h", rsp_id, rsp_product);
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst_rsp_count", 32'(rsp_prod_q.size()), 32'd1);
        @(posedge clk); #1;

        // ---- RUN_CYCLES = 10 instance ----
        b_req0_valid = 1'b1; b_req0_q = 8'h0C; b_req0_m = 8'hFB;
        acc = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (b_req0_ready === 1'b1) begin acc = cyc; break; end
        end
        if (acc < 0) check("rc10_accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        b_req0_valid = 1'b0; b_req0_q = 8'hAA; b_req0_m = 8'h55;
        rc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (b_rsp_valid === 1'b1) begin rc = cyc; break; end
        end
        check("rc10_latency", 32'(rc - acc), 32'd16);
        check("rc10_id", 32'(b_rsp_id), 32'd0);
        check("rc10_product", 32'(b_rsp_product), 32'hFFC4);
        $display("txn rc10: id=%0d product=0x%04h", b_rsp_id, b_rsp_product);
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
